// File: rtl/mem_disp_pkg.sv
// ---------------------------------------------------------------------------
// mem_disp_pkg
//
// Shared constants and types for the memory-content scanning display.
//   SEG_BLANK  : active-low segment pattern with every segment dark
//   ANODE_OFF  : active-low anode pattern with every digit dark
//   SEG_TABLE  : 16-entry hex glyph table, index = nibble, {g,f,e,d,c,b,a}
//   snap_t     : captured {addr, data} pair shown for one whole frame
//   slot_kind_e / slot_kind() / slot_nibble() : which field a digit slot
//                shows and the nibble feeding it
// ---------------------------------------------------------------------------
package mem_disp_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] ANODE_OFF = 8'hFF;

    // Packed array: the leftmost element is index 15 (glyph 'F').
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    // One frame's worth of displayed content.
    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } snap_t;

    // What a digit slot shows: a data nibble, nothing, or an address nibble.
    typedef enum logic [1:0] {
        SLOT_DATA,
        SLOT_BLANK,
        SLOT_ADDR
    } slot_kind_e;

    // Digits 0..3 carry data, 4..5 are spacers, 6..7 carry the address.
    function automatic slot_kind_e slot_kind(input logic [2:0] dig);
        slot_kind_e kind;
        if (dig < 3'd4) begin
            kind = SLOT_DATA;
        end else if (dig < 3'd6) begin
            kind = SLOT_BLANK;
        end else begin
            kind = SLOT_ADDR;
        end
        return kind;
    endfunction

    // Nibble routed to a digit slot; spacer slots return zero (never shown).
    function automatic logic [3:0] slot_nibble(input logic [2:0] dig,
                                               input snap_t    snap);
        logic [3:0] nib;
        case (dig)
            3'd0:    nib = snap.data[3:0];
            3'd1:    nib = snap.data[7:4];
            3'd2:    nib = snap.data[11:8];
            3'd3:    nib = snap.data[15:12];
            3'd6:    nib = snap.addr[3:0];
            3'd7:    nib = snap.addr[7:4];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// ---------------------------------------------------------------------------
// hex7seg
//
// Combinational hex-to-seven-segment decoder, active-low outputs.
//   i_nib : 4-bit value to display
//   o_seg : segment drive {g,f,e,d,c,b,a}, 0 lights a segment
// ---------------------------------------------------------------------------
module hex7seg
    import mem_disp_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/mem_disp_scan.sv
// ---------------------------------------------------------------------------
// mem_disp_scan
//
// Eight-digit multiplexed display that shows one memory word per frame:
// digits 3..0 show data[15:0], digits 5..4 are blank spacers and digits 7..6
// show addr[7:0]. Each digit is lit for PRESCALE clocks; the {addr,data}
// pair is sampled once per frame so the picture never tears mid-frame.
//
// Parameters
//   PRESCALE    : clk cycles per digit slot (>= 2)
// Ports
//   clk         : rising-edge clock for all state
//   rst         : asynchronous reset, active low
//   addr        : memory address from the upstream address sequencer
//   data        : memory read data belonging to addr
//   en          : display enable, 0 darkens every digit
//   an          : digit anodes, active low, one-hot-low while shown
//   seg         : segments {g,f,e,d,c,b,a}, active low
//   frame_start : one-cycle pulse in the cycle after a new frame begins
// ---------------------------------------------------------------------------
module mem_disp_scan
    import mem_disp_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  addr,
    input  logic [15:0] data,
    input  logic        en,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        frame_start
);

    localparam int               PRE_W   = $clog2(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [PRE_W-1:0] r_pre;          // position inside the current slot
    logic [2:0]       r_dig;          // digit currently being shown
    snap_t            r_snap;         // frame content
    logic             r_valid;        // a frame has been captured since reset
    logic [7:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_frame_start;

    // -----------------------------------------------------------------------
    // Next-digit selection
    // -----------------------------------------------------------------------
    logic       w_tick;       // last cycle of the current slot
    logic       w_wrap;       // tick that also closes the frame (7 -> 0)
    logic [2:0] w_show_dig;   // digit the output registers load this edge
    snap_t      w_src;        // content that digit is read from
    logic       w_visible;    // something valid to show after this edge
    slot_kind_e w_kind;
    logic [3:0] w_nib;
    logic [6:0] w_hex_seg;

    assign w_tick = (r_pre == PRE_MAX);
    assign w_wrap = w_tick && (r_dig == 3'd7);

    // NOTE: every signal written in an always_comb block is given a default
    // first, so no path through the block can leave it unassigned (latch).
    always_comb begin
        w_show_dig = r_dig;
        w_src      = r_snap;
        if (w_tick) begin
            w_show_dig = r_dig + 3'd1;
        end
        // On the frame wrap the snapshot is being reloaded on this very edge,
        // so digit 0 must be decoded from the live inputs to stay in step.
        if (w_wrap) begin
            w_src = {addr, data};
        end
    end

    // Between ticks neither the digit nor the snapshot moves, so reloading
    // the output registers every cycle only changes them on a tick. It also
    // restores the current digit on the first edge after en returns high.
    assign w_visible = r_valid || w_wrap;
    assign w_kind    = slot_kind(w_show_dig);
    assign w_nib     = slot_nibble(w_show_dig, w_src);

    hex7seg u_hex7seg (
        .i_nib (w_nib),
        .o_seg (w_hex_seg)
    );

    // -----------------------------------------------------------------------
    // Scan counters and frame snapshot
    // -----------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples values from before the edge, independent of order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // Digit 7 on reset makes the first tick a frame wrap, so display
            // restarts cleanly at digit 0 with freshly captured content.
            r_pre   <= '0;
            r_dig   <= 3'd7;
            r_snap  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
            if (w_tick) begin
                r_dig <= w_show_dig;
            end
            if (w_wrap) begin
                r_snap  <= w_src;
                r_valid <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output registers
    // -----------------------------------------------------------------------
    // NOTE: these are plain flops, not a memory array, so all of them get an
    // asynchronous reset value and the display is dark while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an          <= ANODE_OFF;
            r_seg         <= SEG_BLANK;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_wrap;
            // Until the first wrap after reset there is no frame to show; the
            // display stays dark rather than showing the cleared snapshot.
            if (en && w_visible) begin
                r_an  <= ~(8'h01 << w_show_dig);
                r_seg <= (w_kind == SLOT_BLANK) ? SEG_BLANK : w_hex_seg;
            end else begin
                r_an  <= ANODE_OFF;
                r_seg <= SEG_BLANK;
            end
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_mem_disp_scan.sv
// ---------------------------------------------------------------------------
// tb_mem_disp_scan
//
// Self-checking bench for mem_disp_scan with PRESCALE = 4. A cycle-level
// reference model predicts an/seg/frame_start for every clock edge; the
// prediction is queued when the inputs for that edge are driven and popped
// and compared once the DUT has updated. Directed checks with literal values
// mark the key points of each scenario.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_disp_scan;

    localparam int PRESCALE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr;
    logic [15:0] data;
    logic        en;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        frame_start;

    always #5 clk = ~clk;

    mem_disp_scan #(.PRESCALE(PRESCALE)) dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .data        (data),
        .en          (en),
        .an          (an),
        .seg         (seg),
        .frame_start (frame_start)
    );

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       fs;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int          m_pre;
    int          m_dig;
    logic [7:0]  m_addr;
    logic [15:0] m_data;
    bit          m_valid;
    bit          last_fs;
    int          fs_seen;

    logic [7:0] seq_an  [7] = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [6:0] seq_seg [7] = '{7'h0E, 7'h12, 7'h08, 7'h7F, 7'h7F, 7'h46, 7'h30};

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [6:0] digit_seg(input int d);
        case (d)
            0: return seg_code(m_data[3:0]);
            1: return seg_code(m_data[7:4]);
            2: return seg_code(m_data[11:8]);
            3: return seg_code(m_data[15:12]);
            6: return seg_code(m_addr[3:0]);
            7: return seg_code(m_addr[7:4]);
            default: return 7'h7F;
        endcase
    endfunction

    task automatic model_reset();
        m_pre   = 0;
        m_dig   = 7;
        m_addr  = '0;
        m_data  = '0;
        m_valid = 0;
    endtask

    // Predict the coming edge from the inputs now applied, then advance one
    // clock and compare the DUT against the queued prediction.
    task automatic step();
        exp_t e;
        exp_t got_exp;
        bit   tick;
        tick = (m_pre == PRESCALE - 1);
        e.fs = tick && (m_dig == 7);
        if (e.fs) begin
            m_addr  = addr;
            m_data  = data;
            m_valid = 1;
        end
        if (tick) m_dig = (m_dig + 1) % 8;
        m_pre = tick ? 0 : m_pre + 1;
        if (en && m_valid) begin
            e.an  = ~(8'h01 << m_dig);
            e.seg = digit_seg(m_dig);
        end else begin
            e.an  = 8'hFF;
            e.seg = 7'h7F;
        end
        sb_q.push_back(e);
        last_fs = e.fs;
        @(posedge clk);
        #1;
        got_exp = sb_q.pop_front();
        check("an", an, got_exp.an);
        check("seg", seg, got_exp.seg);
        check("frame_start", frame_start, got_exp.fs);
        if (frame_start) fs_seen++;
    endtask

    // Step until the model sees a frame wrap; n = edges taken.
    task automatic run_to_wrap(output int n);
        bit found;
        found = 0;
        n = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            n++;
            found = last_fs;
        end
        if (!found) check("wrap_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state.
        rst  = 1'b0;
        en   = 1'b1;
        addr = 8'h3C;
        data = 16'hA5F1;
        model_reset();
        fs_seen = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", an, 8'hFF);
        check("rst_seg", seg, 7'h7F);
        check("rst_fs", frame_start, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // First tick after release is a wrap showing digit 0.
        run_to_wrap(n);
        check("first_wrap_edges", n, 4);
        check("d0_an", an, 8'hFE);
        check("d0_seg", seg, 7'h79);
        check("d0_fs", frame_start, 1'b1);

        // Remaining digits of the frame.
        for (int i = 0; i < 7; i++) begin
            repeat (4) step();
            check("seq_an", an, seq_an[i]);
            check("seq_seg", seg, seq_seg[i]);
        end

        // Data change mid-frame does not tear the picture.
        run_to_wrap(n);
        check("wrap2_edges", n, 4);
        repeat (8) step();
        data = 16'h0000;
        repeat (4) step();
        check("notear_an", an, 8'hF7);
        check("notear_seg", seg, 7'h08);
        run_to_wrap(n);
        check("newdata_an", an, 8'hFE);
        check("newdata_seg", seg, 7'h40);

        // Display disable mid-frame for 10 edges.
        repeat (4) step();
        en = 1'b0;
        step();
        check("dis_an", an, 8'hFF);
        repeat (9) step();
        en = 1'b1;
        step();
        check("reen_an", an, 8'hF7);
        check("reen_seg", seg, 7'h40);
        data = 16'h1234;
        run_to_wrap(n);
        check("reen_wrap_edges", n, 17);

        // Asynchronous reset while digit 5 is shown.
        repeat (20) step();
        check("pre_rst_an", an, 8'hDF);
        #2;
        rst = 1'b0;
        #1;
        check("arst_an", an, 8'hFF);
        check("arst_seg", seg, 7'h7F);
        check("arst_fs", frame_start, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        check("arst_hold_an", an, 8'hFF);
        @(negedge clk);
        rst = 1'b1;
        run_to_wrap(n);
        check("arst_wrap_edges", n, 4);
        check("arst_d0_an", an, 8'hFE);
        check("arst_d0_seg", seg, 7'h19);

        // Address sweep across 256 frames.
        fs_seen = 0;
        for (int k = 0; k < 256; k++) begin
            addr = 8'(k);
            data = 16'($urandom);
            run_to_wrap(n);
            check("sweep_frame_edges", n, 32);
        end
        repeat (28) step();
        check("sweep_frame_count", fs_seen, 256);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_disp_scan.md
MEM_DISP_SCAN -- requirements
Module: mem_disp_scan

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000, meaning clk cycles per digit slot (minimum 2).
REQ-002 SHALL have one clock, clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 SHALL have addr  input  8  memory address from the upstream address sequencer.
REQ-005 SHALL have data  input  16  memory read data for addr.
REQ-006 SHALL have en  input  1  display enable; 0 blanks all digits.
REQ-007 SHALL have an  output  8  digit anodes, active-low, one-hot-low when enabled.
REQ-008 SHALL have seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 SHALL have frame_start  output  1  one-cycle pulse at each frame start; may gate the address sequencer.

Function
REQ-010 SHALL count prescaler pre from 0 to PRESCALE-1 and wrap; tick = (pre == PRESCALE-1).
REQ-011 SHALL hold 3-bit digit index dig, changing only on tick: dig <= dig+1 mod 8.
REQ-012 SHALL, on tick with dig==7, load snapshot {addr,data} from the live inputs; snapshot otherwise holds.
REQ-013 SHALL map digits: 0..3 = data nibbles [3:0]..[15:12]; 4,5 = blank (seg 7'h7F); 6,7 = addr nibbles [3:0],[7:4].
REQ-014 SHALL register an and seg on tick for the new dig value; on the 7->0 tick, digit 0 uses live data[3:0] so it matches the snapshot loaded on the same edge.
REQ-015 SHALL encode hex active-low: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E (hex).
REQ-016 SHALL drive an = ~(8'b1 << dig) while en=1.
REQ-017 SHALL, while en=0, drive an=8'hFF from the first rising edge after en falls; pre, dig and snapshot keep running.
REQ-018 SHALL restore the current digit's an/seg on the first edge after en rises, without waiting for a tick.
REQ-019 SHALL assert frame_start for exactly the one cycle following the 7->0 tick edge; never otherwise.
REQ-020 SHALL ignore addr/data changes between frame boundaries (no tearing within a frame).

Reset
REQ-021 SHALL, while rst=0, force pre=0, dig=7, snapshot=0, an=8'hFF, seg=7'h7F, frame_start=0.
REQ-022 SHALL make the first tick after reset release a 7->0 wrap: capture inputs, show digit 0, pulse frame_start.
REQ-023 SHALL abandon any partial frame on reset mid-operation; no stale digit shown after release.

Structure
REQ-024 SHALL place the 16-entry segment table, SEG_BLANK=7'h7F and ANODE_OFF=8'hFF in shared package mem_disp_pkg.
REQ-025 SHALL instantiate exactly one combinational sub-module, hex7seg (4-bit nibble in, 7-bit seg out).
REQ-026 SHALL be implemented as a registered design only; no latches, no derived clocks.

Verification (PRESCALE=4)
REQ-027 SHALL cover: reset release, addr=8'h3C, data=16'hA5F1 -> cycle 4 edge: an=FE, seg=79, frame_start high for 1 cycle.
REQ-028 SHALL cover: continuing the same stimulus -> every 4 cycles seg = 0E,12,08, then 7F,7F, then 46,30, for an = FD,FB,F7,EF,DF,BF,7F.
REQ-029 SHALL cover: data changed to 16'h0000 mid-frame -> digits keep A5F1 until next wrap, then digit 0 shows 40.
REQ-030 SHALL cover: en=0 for 10 cycles mid-frame -> an=FF next edge; on en=1, an/seg match dig, and frame_start timing is unchanged.
REQ-031 SHALL cover: rst=0 asserted at dig=5 -> an=FF and seg=7F immediately (asynchronous); after release, first tick shows digit 0.
REQ-032 SHALL cover: addr swept 00..FF across 256 frames -> digits 7:6 display each value once, and frame_start count equals 256.
